// File: rtl/bitstream_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bitstream_window_sequencer
// Brief    : Evaluation-window sequencer and per-channel ones accumulator for
//            stochastic bitstream networks, unipolar or bipolar result output.
// Revision : 1.0 - initial release
// ============================================================================
module bitstream_window_sequencer #(
    parameter int N_CH    = 1,
    parameter int LENGTH  = 256,
    parameter int LATENCY = 0,
    parameter int CNT_W   = $clog2(LENGTH) + 1,
    parameter int RES_W   = CNT_W + 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    bipolar,
    input  logic [N_CH-1:0]         bitstream_in,
    output logic                    compute,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [N_CH*RES_W-1:0]   result
);

    localparam int c_MAX_CYC = (LATENCY > LENGTH) ? LATENCY : LENGTH;
    localparam int c_CYC_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam logic [c_CYC_W-1:0] c_SKIP_LAST  = c_CYC_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [c_CYC_W-1:0] c_COUNT_LAST = c_CYC_W'(LENGTH - 1);
    localparam logic [RES_W-1:0]   c_LEN_RES    = RES_W'(LENGTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_COUNT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_CYC_W-1:0]     r_cyc;
    logic [CNT_W-1:0]       r_cnt [N_CH];
    logic                   r_bipolar;

    logic [CNT_W-1:0]       w_cnt_next [N_CH];
    logic [N_CH*RES_W-1:0]  w_res_final;
    logic                   w_accept;
    state_t                 w_first_state;

    // A start is taken from IDLE, or from HOLD when the result is consumed in the same cycle.
    assign w_accept      = start && ((r_state == S_IDLE) ||
                                     ((r_state == S_HOLD) && result_ready));
    assign w_first_state = (LATENCY > 0) ? S_SKIP : S_COUNT;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic [RES_W-1:0] w_uni;
            logic [RES_W-1:0] w_bip;

            assign w_cnt_next[c] = r_cnt[c] + CNT_W'(bitstream_in[c]);
            assign w_uni         = RES_W'(w_cnt_next[c]);
            // 2n - LENGTH; 2n always fits in RES_W bits, so modular subtraction gives the signed value.
            assign w_bip         = {w_uni[RES_W-2:0], 1'b0} - c_LEN_RES;
            assign w_res_final[c*RES_W +: RES_W] = r_bipolar ? w_bip : w_uni;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_bipolar    <= 1'b0;
            compute      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        r_state      <= w_first_state;
                        r_cyc        <= '0;
                        r_bipolar    <= bipolar;
                        compute      <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        for (int c = 0; c < N_CH; c++) begin
                            r_cnt[c] <= '0;
                        end
                    end else if ((r_state == S_HOLD) && result_ready) begin
                        r_state      <= S_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (r_cyc == c_SKIP_LAST) begin
                        r_state <= S_COUNT;
                        r_cyc   <= '0;
                    end else begin
                        r_cyc <= r_cyc + c_CYC_W'(1);
                    end
                end
                S_COUNT: begin
                    for (int c = 0; c < N_CH; c++) begin
                        r_cnt[c] <= w_cnt_next[c];
                    end
                    // The final bit is folded into the result through w_cnt_next.
                    if (r_cyc == c_COUNT_LAST) begin
                        r_state      <= S_HOLD;
                        r_cyc        <= '0;
                        compute      <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= w_res_final;
                    end else begin
                        r_cyc <= r_cyc + c_CYC_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitstream_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitstream_window_sequencer
// Brief    : Scoreboard bench; instance A has LATENCY=0/two channels, B has LATENCY=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitstream_window_sequencer;

    localparam int LEN = 256;
    localparam int RW  = 10;

    typedef struct {
        int v0;
        int v1;
    } exp_t;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start_v [2];
    logic              bip_v   [2];
    logic [1:0]        bs_v    [2];
    logic              ready_v [2];
    logic              comp_w  [2];
    logic              busy_w  [2];
    logic              valid_w [2];
    logic [2*RW-1:0]   res_a;
    logic [RW-1:0]     res_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bitstream_window_sequencer #(.N_CH(2), .LENGTH(LEN), .LATENCY(0)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_v[0]), .bipolar(bip_v[0]),
        .bitstream_in(bs_v[0]), .compute(comp_w[0]), .busy(busy_w[0]),
        .result_valid(valid_w[0]), .result_ready(ready_v[0]), .result(res_a)
    );

    bitstream_window_sequencer #(.N_CH(1), .LENGTH(LEN), .LATENCY(2)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_v[1]), .bipolar(bip_v[1]),
        .bitstream_in(bs_v[1][0]), .compute(comp_w[1]), .busy(busy_w[1]),
        .result_valid(valid_w[1]), .result_ready(ready_v[1]), .result(res_b)
    );

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    function automatic int get_res(input int d, input int ch);
        logic signed [RW-1:0] t;
        if (d == 0) t = (ch == 0) ? res_a[RW-1:0] : res_a[2*RW-1:RW];
        else        t = res_b;
        return int'(t);
    endfunction

    // Pattern 0: ch0 ones, ch1 zeros. 1: ch0 1010.., ch1 ones.
    // 2: both ones only for i<2. 3: ch0 every third bit, ch1 first 100 bits.
    function automatic logic [1:0] bits(input int pat, input int i);
        case (pat)
            0:       return 2'b01;
            1:       return {1'b1, (i % 2 == 0)};
            2:       return (i < 2) ? 2'b11 : 2'b00;
            default: return {(i < 100), (i % 3 == 0)};
        endcase
    endfunction

    // Scoreboard monitor: pops an expectation at every result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst) begin
            if (valid_w[0] && ready_v[0]) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_result", 1, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_result_ch0", get_res(0, 0), e.v0);
                    check("a_result_ch1", get_res(0, 1), e.v1);
                end
            end
            if (valid_w[1] && ready_v[1]) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_result", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_result_ch0", get_res(1, 0), e.v0);
                end
            end
        end
    end

    task automatic run_window(input int d, input bit bip, input int pat, input int e0,
                              input int e1, input int rdly, input bit mid_start,
                              input bit b2b, input bit already);
        int   lat;
        int   tot;
        int   nhigh;
        exp_t e;
        lat = (d == 0) ? 0 : 2;
        tot = lat + LEN;
        e.v0 = e0;
        e.v1 = e1;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
        if (!already) begin
            bip_v[d]   = bip;
            start_v[d] = 1'b1;
            @(posedge clk); #1;
            start_v[d] = 1'b0;
        end
        nhigh = 0;
        for (int i = 0; i < tot; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (comp_w[d]) nhigh++;
            bs_v[d] = bits(pat, i);
            if (i == 5) bip_v[d] = !bip;
            if (mid_start) start_v[d] = (i == 100);
        end
        @(posedge clk); #1;
        bip_v[d]   = bip;
        bs_v[d]    = 2'b00;
        start_v[d] = 1'b0;
        check("compute_len", nhigh, tot);
        check("compute_fall", int'(comp_w[d]), 0);
        check("valid_rise", int'(valid_w[d]), 1);
        check("busy_in_hold", int'(busy_w[d]), 1);
        for (int r = 0; r < rdly; r++) begin
            start_v[d] = r[0];
            @(posedge clk); #1;
            check("hold_valid", int'(valid_w[d]), 1);
            check("hold_ch0", get_res(d, 0), e0);
        end
        ready_v[d] = 1'b1;
        start_v[d] = b2b;
        @(posedge clk); #1;
        ready_v[d] = 1'b0;
        start_v[d] = 1'b0;
        check("valid_fall", int'(valid_w[d]), 0);
        check("busy_after", int'(busy_w[d]), b2b ? 1 : 0);
        check("compute_after", int'(comp_w[d]), b2b ? 1 : 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            bip_v[d]   = 1'b0;
            bs_v[d]    = 2'b00;
            ready_v[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_compute", int'(comp_w[d]), 0);
            check("rst_busy", int'(busy_w[d]), 0);
            check("rst_valid", int'(valid_w[d]), 0);
        end
        check("rst_result_a", int'(res_a), 0);
        check("rst_result_b", int'(res_b), 0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        run_window(0, 1'b0, 0, 256, 0, 0, 1'b0, 1'b0, 1'b0);
        run_window(0, 1'b1, 0, 256, -256, 10, 1'b0, 1'b1, 1'b0);
        run_window(0, 1'b1, 1, 0, 256, 0, 1'b1, 1'b0, 1'b1);
        run_window(0, 1'b0, 1, 128, 256, 0, 1'b0, 1'b0, 1'b0);
        run_window(0, 1'b0, 2, 2, 2, 3, 1'b0, 1'b0, 1'b0);
        run_window(0, 1'b1, 3, -84, -56, 0, 1'b0, 1'b0, 1'b0);
        run_window(1, 1'b0, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_window(1, 1'b1, 0, 256, 0, 2, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a window discards everything.
        bip_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bs_v[0] = 2'b11;
            @(posedge clk); #1;
        end
        check("pre_rst_compute", int'(comp_w[0]), 1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_compute", int'(comp_w[0]), 0);
        check("mid_rst_busy", int'(busy_w[0]), 0);
        check("mid_rst_valid", int'(valid_w[0]), 0);
        check("mid_rst_result", int'(res_a), 0);
        check("mid_rst_result_b", int'(res_b), 0);
        bs_v[0] = 2'b00;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle_valid", int'(valid_w[0]), 0);
        run_window(0, 1'b0, 3, 86, 100, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitstream_window_sequencer.md
# bitstream_window_sequencer

Hardware sequencer and multi-channel accumulator for stochastic bitstream networks. On each start request it holds the network's `compute` enable high for one evaluation window and counts the ones on every output bitstream channel, skipping a programmable pipeline-latency prefix. It then presents per-channel results in unipolar (count) or bipolar (signed) form behind a valid/ready handshake. It sits between a network instance and the sample-feeding / result-logging logic and replaces software-driven window timing.

## Interface

Parameters:
- `N_CH`, 1: number of network output bitstream channels.
- `LENGTH`, 256: counted bits per window, ≥ 2.
- `LATENCY`, 0: cycles between `compute` rising and the first valid network output bit; these bits are not counted.
- `CNT_W`, $clog2(LENGTH)+1: ones-counter width; must represent `LENGTH` exactly.
- `RES_W`, CNT_W+1: result width, two's complement.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one evaluation window; sampled only when accepted (see Operation).
- `bipolar`  in  1  result mode, latched at start acceptance: 0 unipolar, 1 bipolar.
- `bitstream_in`  in  N_CH  one network output bit per channel per cycle.
- `compute`  out  1  network enable; high for exactly LATENCY+LENGTH cycles per window.
- `busy`  out  1  high from start acceptance until the result handshake completes.
- `result_valid`  out  1  results stable and valid.
- `result_ready`  in  1  consumer accepts results when high together with `result_valid`.
- `result`  out  N_CH×RES_W  per-channel signed result, channel c at bits [c*RES_W +: RES_W].

## Operation

- FSM states: IDLE, SKIP, COUNT, HOLD.
- IDLE: `start`=1 → latch `bipolar`, clear all channel counters and the cycle counter. Go to SKIP if LATENCY>0, otherwise COUNT.
- SKIP: `compute`=1 for LATENCY cycles. `bitstream_in` is ignored. Then go to COUNT.
- COUNT: `compute`=1 for LENGTH cycles. Each channel counter increments when its bit is 1. After the LENGTH-th counted bit, go to HOLD.
- HOLD: `compute`=0 and `result_valid`=1. Results are frozen while `result_ready`=0.
  - `result_ready`=1 → go to IDLE.
  - If `start`=1 in the same cycle, accept it directly (back-to-back): go to SKIP/COUNT and do not pass through IDLE.
- Result arithmetic per channel, with ones count n (0..LENGTH):
  - unipolar: `result` = n, zero-extended.
  - bipolar: `result` = 2n − LENGTH, signed, range −LENGTH..+LENGTH.
- The cycle counter wraps to 0 on every state transition. Channel counters never saturate, because CNT_W covers LENGTH.
- `start` in SKIP or COUNT is ignored; there is no queueing. `start` in HOLD without `result_ready` is ignored.
- `bipolar` changes after acceptance have no effect until the next window.

## Timing

- Reset values: `compute`=0, `busy`=0, `result_valid`=0, `result`=0. State is IDLE and all counters are 0.
- `start` accepted at edge k:
  - `compute` and `busy` rise after edge k.
  - `bitstream_in` is counted on edges k+LATENCY+1 … k+LATENCY+LENGTH.
  - `compute` falls and `result_valid` rises after edge k+LATENCY+LENGTH.
- `result_valid`=1 and `result_ready`=1 at edge m: `result_valid` falls after m. `busy` falls after m unless a back-to-back start is taken at m.
- `result` updates only on the transition into HOLD. It holds its last value in IDLE and during the next window.
- Reset asserted at any time, including mid-window or in HOLD: all outputs return to their reset values immediately. Partial counts are discarded and no result is produced.

## Test plan

- LENGTH=256, LATENCY=0, N_CH=2, unipolar; ch0 all ones, ch1 all zeros → `compute` high exactly 256 cycles; results 256 and 0; `result_valid` rises the cycle after the last bit.
- Same stimulus, bipolar → results +256 and −256. Alternating 1010… on ch0 → 0 in bipolar, 128 in unipolar.
- LATENCY=2; bitstream ones only during the first 2 cycles of the window, zeros after → result 0, proving the skip prefix is not counted. `compute` high for 258 cycles.
- Backpressure: `result_ready` held low 10 cycles after valid → `result_valid` and values stable. `start` pulses during HOLD are ignored. `result_ready`+`start` in the same cycle → next window begins with no IDLE cycle.
- `start` pulsed mid-COUNT → ignored; window length unchanged.
- `n_rst` pulsed at cycle 100 of a window → `compute`/`busy`/`result_valid`/`result` go to 0 immediately. A fresh start then yields correct counts from zero.
